obi_req_hold_buffer: RTL and testbench
======================================

// Module: obi_req_hold_buffer
// PURPOSE
// - Controller-side staging buffer placed directly upstream of the fast-primary OBI CDC bridge, in the controller clock domain.
// - Accepts one OBI transaction from the core, registers it, and holds req/addr/we/be/wdata stable until the bridge grants it.
// - Then waits for the response and enforces a minimum req-low gap so the bridge's synchronisers never see a merged or duplicated request.
// - Strictly one outstanding transaction. Response is returned to the core registered.
// PARAMETERS
// - HOLDOFF_CYCLES  default 4     clk_i cycles dn_req_o stays low after rvalid before the next request may issue (>=1)
// - TIMEOUT_CYCLES  default 1024  cycles without dn_gnt_i / dn_rvalid_i before abort; 0 disables the watchdog
// PORTS
// - clk_i           in   1   controller clock
// - reset_i         in   1   asynchronous, active-high reset
// - up_req_i        in   1   core request
// - up_gnt_o        out  1   grant to core (combinational)
// - up_addr_i       in   32  core address
// - up_we_i         in   1   core write enable
// - up_be_i         in   4   core byte enables
// - up_wdata_i      in   32  core write data
// - up_rvalid_o     out  1   response valid to core (registered, 1-cycle pulse)
// - up_rdata_o      out  32  response data to core (registered)
// - up_err_o        out  1   response error; valid only with up_rvalid_o
// - dn_req_o        out  1   request to CDC bridge (registered level)
// - dn_gnt_i        in   1   grant pulse from CDC bridge
// - dn_addr_o       out  32  held address
// - dn_we_o         out  1   held write enable
// - dn_be_o         out  4   held byte enables
// - dn_wdata_o      out  32  held write data
// - dn_rvalid_i     in   1   response valid from bridge
// - dn_rdata_i      in   32  response data from bridge
// - timeout_o       out  1   sticky watchdog flag; cleared only by reset
// BEHAVIOUR
// - Reset (async assert, removal synchronous to clk_i): state=IDLE; all outputs 0, including the held dn_* payload; timeout_o=0; counters=0.
// - FSM states: IDLE, REQ, RSP, HOLD.
// - IDLE: up_gnt_o = up_req_i. On up_req_i, capture addr/we/be/wdata into the hold registers, set dn_req_o=1 next cycle, go to REQ.
// - up_gnt_o is 0 in every state other than IDLE.
// - REQ: dn_req_o=1 and dn_* payload frozen. On dn_gnt_i, dn_req_o=0 next cycle and go to RSP.
// - RSP: dn_req_o=0. On dn_rvalid_i, register dn_rdata_i into up_rdata_o, pulse up_rvalid_o with up_err_o=0 next cycle, go to HOLD.
// - dn_gnt_i and dn_rvalid_i in the same REQ cycle: treat as grant then response. Go straight to HOLD with the response returned.
// - HOLD: count HOLDOFF_CYCLES cycles, then go to IDLE. up_req_i is ignored here and not granted.
// - Latency: dn_req_o rises 1 cycle after up_gnt_o; up_rvalid_o rises 1 cycle after dn_rvalid_i.
// - Min req-low gap between transactions = 1 + HOLDOFF_CYCLES.
// - dn_gnt_i outside REQ and dn_rvalid_i outside REQ/RSP are ignored; no state change.
// - Watchdog: the counter resets on entry to REQ and to RSP and increments each cycle spent in REQ or RSP.
// - On the watchdog reaching TIMEOUT_CYCLES: drop dn_req_o, pulse up_rvalid_o with up_err_o=1 and up_rdata_o=0, set timeout_o, go to HOLD.
// - Watchdog counter width is clog2(TIMEOUT_CYCLES+1); the holdoff counter saturates and never wraps.
// - Reset mid-transaction: everything returns to IDLE immediately; any pending response is dropped; no up_rvalid_o is generated.
// TESTING
// - Reset, then up_req_i=1 with addr=0x1000_0004, we=0: up_gnt_o=1 same cycle; dn_req_o=1 and dn_addr_o=0x1000_0004 next cycle.
// - Write wdata=0xDEADBEEF, be=0xF; change up_* inputs during REQ: dn_* stays at the captured values until dn_gnt_i.
// - dn_gnt_i, then dn_rvalid_i 5 cycles later with rdata=0xCAFE_F00D: up_rvalid_o pulses 1 cycle later with up_rdata_o=0xCAFE_F00D, up_err_o=0.
// - up_req_i held high across back-to-back transactions (HOLDOFF_CYCLES=4): dn_req_o stays low >=5 cycles between them; no second grant during HOLD.
// - TIMEOUT_CYCLES=16 and dn_gnt_i never asserted: at cycle 16 dn_req_o=0, up_rvalid_o=1, up_err_o=1, timeout_o=1 and stays high.
// - Assert reset_i while in RSP: all outputs 0 asynchronously; a late dn_rvalid_i after reset removal produces no up_rvalid_o.

Source files
------------

// File: rtl/obi_req_hold_buffer.sv
// Staging buffer between the core and the fast-primary OBI CDC bridge. It holds a
// single request stable until granted and keeps req low long enough between requests.
module obi_req_hold_buffer #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        up_req_i,
  output logic        up_gnt_o,
  input  logic [31:0] up_addr_i,
  input  logic        up_we_i,
  input  logic [3:0]  up_be_i,
  input  logic [31:0] up_wdata_i,
  output logic        up_rvalid_o,
  output logic [31:0] up_rdata_o,
  output logic        up_err_o,
  output logic        dn_req_o,
  input  logic        dn_gnt_i,
  output logic [31:0] dn_addr_o,
  output logic        dn_we_o,
  output logic [3:0]  dn_be_o,
  output logic [31:0] dn_wdata_o,
  input  logic        dn_rvalid_i,
  input  logic [31:0] dn_rdata_i,
  output logic        timeout_o
);

  localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);
  localparam int WD_W   = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WD_W-1:0]    wd_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               capture, respond, abort;
  logic               wd_hit, hold_done;

  // Fires on the cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign wd_hit    = WD_EN && ((wd_cnt + WD_W'(1)) == WD_W'(TIMEOUT_CYCLES));
  assign hold_done = (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    up_gnt_o = 1'b0;
    capture  = 1'b0;
    respond  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        up_gnt_o = up_req_i;
        if (up_req_i) begin
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dn_gnt_i) begin
          // A response arriving with its grant completes the transaction at once.
          if (dn_rvalid_i) begin
            respond = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = RSP;
          end
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      RSP: begin
        if (dn_rvalid_i) begin
          respond = 1'b1;
          state_d = HOLD;
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dn_req_o    <= 1'b0;
      dn_addr_o   <= '0;
      dn_we_o     <= 1'b0;
      dn_be_o     <= '0;
      dn_wdata_o  <= '0;
      up_rvalid_o <= 1'b0;
      up_rdata_o  <= '0;
      up_err_o    <= 1'b0;
      timeout_o   <= 1'b0;
      wd_cnt      <= '0;
      hold_cnt    <= '0;
    end else begin
      up_rvalid_o <= respond | abort;
      up_err_o    <= abort;
      if (respond)    up_rdata_o <= dn_rdata_i;
      else if (abort) up_rdata_o <= '0;
      if (abort) timeout_o <= 1'b1;

      if (capture) begin
        dn_req_o   <= 1'b1;
        dn_addr_o  <= up_addr_i;
        dn_we_o    <= up_we_i;
        dn_be_o    <= up_be_i;
        dn_wdata_o <= up_wdata_i;
      end else if (state_q == REQ && state_d != REQ) begin
        dn_req_o <= 1'b0;
      end

      if (state_d != state_q && (state_d == REQ || state_d == RSP))
        wd_cnt <= '0;
      else if (WD_EN && (state_q == REQ || state_q == RSP))
        wd_cnt <= wd_cnt + WD_W'(1);

      if (state_d == HOLD && state_q != HOLD)
        hold_cnt <= '0;
      else if (state_q == HOLD && hold_cnt != HOLD_W'(HOLDOFF_CYCLES))
        hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_obi_req_hold_buffer.sv
// Directed bench for obi_req_hold_buffer: HOLDOFF_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_obi_req_hold_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        up_req_i;
  logic        up_gnt_o;
  logic [31:0] up_addr_i;
  logic        up_we_i;
  logic [3:0]  up_be_i;
  logic [31:0] up_wdata_i;
  logic        up_rvalid_o;
  logic [31:0] up_rdata_o;
  logic        up_err_o;
  logic        dn_req_o;
  logic        dn_gnt_i;
  logic [31:0] dn_addr_o;
  logic        dn_we_o;
  logic [3:0]  dn_be_o;
  logic [31:0] dn_wdata_o;
  logic        dn_rvalid_i;
  logic [31:0] dn_rdata_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  obi_req_hold_buffer #(.HOLDOFF_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .up_req_i(up_req_i), .up_gnt_o(up_gnt_o), .up_addr_i(up_addr_i),
    .up_we_i(up_we_i), .up_be_i(up_be_i), .up_wdata_i(up_wdata_i),
    .up_rvalid_o(up_rvalid_o), .up_rdata_o(up_rdata_o), .up_err_o(up_err_o),
    .dn_req_o(dn_req_o), .dn_gnt_i(dn_gnt_i), .dn_addr_o(dn_addr_o),
    .dn_we_o(dn_we_o), .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o),
    .dn_rvalid_i(dn_rvalid_i), .dn_rdata_i(dn_rdata_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    up_req_i = 0; up_addr_i = 0; up_we_i = 0; up_be_i = 0; up_wdata_i = 0;
    dn_gnt_i = 0; dn_rvalid_i = 0; dn_rdata_i = 0;
  endtask

  task automatic test_reset();
    logic [107:0] outs;
    idle_inputs();
    reset_i = 1;
    tick(); tick();
    outs = {up_gnt_o, up_rvalid_o, up_rdata_o, up_err_o, dn_req_o, dn_addr_o,
            dn_we_o, dn_be_o, dn_wdata_o, timeout_o};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset_i = 0;
    tick();
  endtask

  task automatic test_read();
    up_req_i = 1; up_addr_i = 32'h1000_0004; up_we_i = 0; up_be_i = 4'hF;
    #1;
    n_checks++;
    if (up_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL read_gnt_same_cycle: got %b want 1", up_gnt_o);
    end
    tick();
    up_req_i = 0;
    n_checks++;
    if ({dn_req_o, dn_addr_o, dn_we_o} !== {1'b1, 32'h1000_0004, 1'b0}) begin
      n_fail++; $display("FAIL read_dn_req: got req=%b addr=%h we=%b want 1 10000004 0",
                         dn_req_o, dn_addr_o, dn_we_o);
    end
    dn_gnt_i = 1;
    tick();
    dn_gnt_i = 0;
    n_checks++;
    if (dn_req_o !== 1'b0) begin
      n_fail++; $display("FAIL read_req_drop: got %b want 0", dn_req_o);
    end
    repeat (4) tick();
    dn_rvalid_i = 1; dn_rdata_i = 32'hCAFE_F00D;
    n_checks++;
    if (up_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL read_rvalid_early: got %b want 0", up_rvalid_o);
    end
    tick();
    dn_rvalid_i = 0; dn_rdata_i = 0;
    n_checks++;
    if ({up_rvalid_o, up_rdata_o, up_err_o} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++; $display("FAIL read_rsp: got v=%b d=%h e=%b want 1 cafef00d 0",
                         up_rvalid_o, up_rdata_o, up_err_o);
    end
    tick();
    n_checks++;
    if (up_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL read_rvalid_pulse: got %b want 0", up_rvalid_o);
    end
    repeat (5) tick();
  endtask

  task automatic test_write_hold();
    up_req_i = 1; up_addr_i = 32'h2000_0010; up_we_i = 1; up_be_i = 4'hF;
    up_wdata_i = 32'hDEAD_BEEF;
    tick();
    // Core keeps requesting with new values while the first request is pending.
    up_addr_i = 32'h3333_0000; up_we_i = 0; up_be_i = 4'h1; up_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({dn_req_o, dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o, up_gnt_o} !==
          {1'b1, 32'h2000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0}) begin
        n_fail++; $display("FAIL write_hold[%0d]: got req=%b a=%h we=%b be=%h wd=%h gnt=%b want 1 20000010 1 f deadbeef 0",
                           i, dn_req_o, dn_addr_o, dn_we_o, dn_be_o, dn_wdata_o, up_gnt_o);
      end
      tick();
    end
    dn_gnt_i = 1; dn_rvalid_i = 1; dn_rdata_i = 32'h0000_00AA; up_req_i = 0;
    tick();
    dn_gnt_i = 0; dn_rvalid_i = 0; dn_rdata_i = 0;
    n_checks++;
    if ({dn_req_o, up_rvalid_o, up_rdata_o, up_err_o} !== {1'b0, 1'b1, 32'hAA, 1'b0}) begin
      n_fail++; $display("FAIL write_gnt_rsp_same: got req=%b v=%b d=%h e=%b want 0 1 000000aa 0",
                         dn_req_o, up_rvalid_o, up_rdata_o, up_err_o);
    end
    repeat (5) tick();
  endtask

  task automatic test_stray_inputs();
    dn_gnt_i = 1; dn_rvalid_i = 1; dn_rdata_i = 32'h5555_5555;
    tick(); tick();
    dn_gnt_i = 0; dn_rvalid_i = 0; dn_rdata_i = 0;
    n_checks++;
    if ({dn_req_o, up_rvalid_o, up_rdata_o} !== {1'b0, 1'b0, 32'hAA}) begin
      n_fail++; $display("FAIL stray_idle: got req=%b v=%b d=%h want 0 0 000000aa",
                         dn_req_o, up_rvalid_o, up_rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    int  gap = 0, gnts_in_gap = 0, rsps = 0;
    bit  in_gap = 0, done = 0;
    up_req_i = 1; up_addr_i = 32'h4000_0000;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tick();
      if (up_rvalid_o) rsps++;
      if (dn_req_o) begin
        if (in_gap) begin
          done = 1;
          up_req_i = 0;
        end
        dn_gnt_i = 1; dn_rvalid_i = 1; dn_rdata_i = 32'h7;
      end else begin
        dn_gnt_i = 0; dn_rvalid_i = 0;
        if (!in_gap && rsps > 0) in_gap = 1;
        if (in_gap) begin
          gap++;
          if (up_gnt_o) gnts_in_gap++;
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL b2b_second_req: got none within bound want a second dn_req");
    end
    n_checks++;
    if (gap !== 5) begin
      n_fail++; $display("FAIL b2b_gap: got %0d low cycles want 5", gap);
    end
    n_checks++;
    if (gnts_in_gap !== 1) begin
      n_fail++; $display("FAIL b2b_grants_in_gap: got %0d want 1 (IDLE cycle only)", gnts_in_gap);
    end
    tick();
    dn_gnt_i = 0; dn_rvalid_i = 0; dn_rdata_i = 0;
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    bit early = 0;
    up_req_i = 1; up_addr_i = 32'h5000_0000;
    tick();
    up_req_i = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (dn_req_o !== 1'b1 || up_rvalid_o !== 1'b0 || timeout_o !== 1'b0) early = 1;
    end
    n_checks++;
    if (early) begin
      n_fail++; $display("FAIL timeout_early: got abort before cycle 16 want none");
    end
    tick();
    n_checks++;
    if ({dn_req_o, up_rvalid_o, up_err_o, up_rdata_o, timeout_o} !==
        {1'b0, 1'b1, 1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_abort: got req=%b v=%b e=%b d=%h to=%b want 0 1 1 0 1",
                         dn_req_o, up_rvalid_o, up_err_o, up_rdata_o, timeout_o);
    end
    repeat (8) tick();
    n_checks++;
    if ({timeout_o, up_rvalid_o, up_err_o} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_sticky: got to=%b v=%b e=%b want 1 0 0",
                         timeout_o, up_rvalid_o, up_err_o);
    end
  endtask

  task automatic test_reset_in_rsp();
    logic [107:0] outs;
    up_req_i = 1; up_addr_i = 32'h6000_0000; up_be_i = 4'h3;
    tick();
    up_req_i = 0;
    dn_gnt_i = 1;
    tick();
    dn_gnt_i = 0;
    tick();
    #2 reset_i = 1;
    #1;
    outs = {up_gnt_o, up_rvalid_o, up_rdata_o, up_err_o, dn_req_o, dn_addr_o,
            dn_we_o, dn_be_o, dn_wdata_o, timeout_o};
    n_checks++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", outs);
    end
    tick();
    reset_i = 0;
    dn_rvalid_i = 1; dn_rdata_i = 32'h9999_9999;
    tick();
    dn_rvalid_i = 0; dn_rdata_i = 0;
    n_checks++;
    if ({up_rvalid_o, up_rdata_o, dn_req_o} !== {1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL late_rvalid: got v=%b d=%h req=%b want 0 0 0",
                         up_rvalid_o, up_rdata_o, dn_req_o);
    end
    up_req_i = 1;
    #1;
    n_checks++;
    if (up_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_idle_gnt: got %b want 1", up_gnt_o);
    end
    up_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_hold();
    test_stray_inputs();
    test_back_to_back();
    test_timeout();
    test_reset_in_rsp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
